usb_cdc_loopback_mc: RTL and testbench
======================================

Name: usb_cdc_loopback_mc

Overview:
- Parametrised multi-channel loopback application block between the usb_cdc application interface and the board top.
- Per channel, bytes received from the host (usb_cdc OUT stream) are buffered in a FIFO, optionally transformed, and returned on the IN stream.
- Generalises the single-channel, echo-only loopback example with:
  - N channels
  - configurable buffer depth
  - per-channel mode
  - FIFO level reporting
  - a stretched activity LED

Parameters:
- CHANNELS, 1, number of independent loopback channels (1..7).
- DEPTH, 16, bytes of FIFO per channel; power of two, >= 2.
- ACT_CYCLES, 1600000, clk_i cycles the LED stays lit after the last transfer (100 ms at 16 MHz); >= 1.

Ports:
- clk_i  in  1  application clock (same as usb_cdc app_clk_i).
- rst_i  in  1  asynchronous reset, active high.
- rx_data_i  in  8*CHANNELS  host->device byte per channel (from usb_cdc out_data_o).
- rx_valid_i  in  CHANNELS  rx byte valid per channel.
- rx_ready_o  out  CHANNELS  block accepts rx byte.
- tx_data_o  out  8*CHANNELS  device->host byte per channel (to usb_cdc in_data_i).
- tx_valid_o  out  CHANNELS  tx byte valid.
- tx_ready_i  in  CHANNELS  usb_cdc accepts tx byte.
- mode_i  in  2*CHANNELS  per-channel mode: 0 echo, 1 increment, 2 sink, 3 hold.
- level_o  out  CHANNELS*(log2(DEPTH)+1)  per-channel FIFO occupancy.
- led_o  out  1  activity indicator.

Behaviour:
- Reset: one clock clk_i; reset is asynchronous and active-high (rst_i). While rst_i is asserted, and immediately on its assertion:
  - all FIFOs are emptied and all pointers zeroed
  - level_o = 0, tx_valid_o = 0, tx_data_o = 0, led_o = 0, LED counter = 0
  - rx_ready_o = all ones, except channels whose mode_i is 3 with a full FIFO (not reachable in reset, so all ones)
  - reset mid-transfer discards buffered bytes silently
- Handshakes: a transfer occurs when valid && ready at a rising edge of clk_i. No combinational path from tx_ready_i to rx_ready_o.
- rx_ready_o[c]: 1 if mode 2, else !full[c].
- FIFO: one per channel, first-word-fall-through.
  - A byte pushed at edge N is visible on tx_data_o with tx_valid_o = 1 after edge N (latency 1) when the FIFO was empty.
  - tx_data_o holds stable while tx_valid_o && !tx_ready_i.
- Simultaneous push and pop on the same edge:
  - level unchanged, both succeed
  - when full, a push is refused because rx_ready_o is 0 that cycle, even if a pop occurs
- Pointers: log2(DEPTH) bits, wrap modulo DEPTH. Level counts 0..DEPTH.
- Modes, sampled at the push edge; the transform is applied on write:
  - 0 echo: byte stored unchanged.
  - 1 increment: stores (byte+1) mod 256; 8'hFF becomes 8'h00.
  - 2 sink: bytes accepted and discarded; FIFO not written. Bytes already buffered still drain normally.
  - 3 hold: bytes stored as in echo. tx_valid_o[c] is forced to 0 (FIFO contents kept) until the mode leaves 3. The mode is sampled combinationally, so release is immediate.
- Channels are fully independent; no arbitration between them.
- LED:
  - Any rx or tx handshake on any channel at an edge reloads the counter to ACT_CYCLES-1 and sets led_o = 1 after that edge.
  - Otherwise the counter decrements while nonzero; led_o = 1 while counter != 0 or on a reload.
  - Counter width is log2(ACT_CYCLES)+1; no wrap below 0.

Test Plan:
- CHANNELS=1, DEPTH=16, mode 0: push 8'h01..8'h07 with tx_ready_i=1 -> tx returns 01..07 in order, first byte valid 1 cycle after its push, level_o returns to 0.
- Mode 0, tx_ready_i=0: push 16 bytes 8'h11.. -> level_o=16, rx_ready_o=0. The 17th byte is not accepted. Raise tx_ready_i for 1 cycle while rx_valid_i is held -> one pop, then the 17th byte accepted next edge, level stays 16.
- Mode 1: push 8'h41, 8'hFF -> tx sees 8'h42, 8'h00.
- Mode 3: push 8'h21..8'h24 -> tx_valid_o=0, level_o=4. Switch to mode 0 -> 21..24 drained in order. Mode 2: push 5 bytes -> all accepted, level_o=0, no tx.
- CHANNELS=3: different streams on channels 0 and 2 with tx_ready_i stalled on channel 2 only -> channel 0 drains fully, channel 2 level_o=count pushed, no cross-channel corruption.
- ACT_CYCLES=8: single handshake -> led_o high exactly 8 cycles. Assert rst_i mid-stream with level_o=5 -> level_o=0, tx_valid_o=0, led_o=0 immediately, without a clock edge.

Source files
------------

// File: rtl/usb_cdc_loopback_mc.sv
// Multi-channel usb_cdc loopback: per-channel FWFT FIFO with echo/increment/sink/hold
// transforms on write, occupancy reporting and a stretched activity LED.
module usb_cdc_loopback_mc #(
  parameter int unsigned CHANNELS   = 1,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ACT_CYCLES = 1600000
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic [8*CHANNELS-1:0]                    rx_data_i,
  input  logic [CHANNELS-1:0]                      rx_valid_i,
  output logic [CHANNELS-1:0]                      rx_ready_o,
  output logic [8*CHANNELS-1:0]                    tx_data_o,
  output logic [CHANNELS-1:0]                      tx_valid_o,
  input  logic [CHANNELS-1:0]                      tx_ready_i,
  input  logic [2*CHANNELS-1:0]                    mode_i,
  output logic [CHANNELS*($clog2(DEPTH)+1)-1:0]    level_o,
  output logic                                     led_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = $clog2(ACT_CYCLES) + 1;

  localparam logic [1:0] MODE_ECHO = 2'd0;
  localparam logic [1:0] MODE_INC  = 2'd1;
  localparam logic [1:0] MODE_SINK = 2'd2;
  localparam logic [1:0] MODE_HOLD = 2'd3;

  logic [CHANNELS-1:0] rx_hs;
  logic [CHANNELS-1:0] tx_hs;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] count;
    logic [1:0]    mode;
    logic [7:0]    rx_byte;
    logic [7:0]    wr_byte;
    logic          full;
    logic          empty;
    logic          wr_en;

    assign mode    = mode_i[2*c +: 2];
    assign rx_byte = rx_data_i[8*c +: 8];
    assign full    = (count == LW'(DEPTH));
    assign empty   = (count == '0);

    // Sink always accepts; hold keeps filling but never offers data.
    assign rx_ready_o[c]       = (mode == MODE_SINK) || !full;
    assign tx_valid_o[c]       = !empty && (mode != MODE_HOLD);
    assign tx_data_o[8*c +: 8] = empty ? 8'h00 : mem[rd_ptr];
    assign level_o[LW*c +: LW] = count;

    assign rx_hs[c] = rx_valid_i[c] && rx_ready_o[c];
    assign tx_hs[c] = tx_valid_o[c] && tx_ready_i[c];
    assign wr_en    = rx_hs[c] && (mode != MODE_SINK);
    assign wr_byte  = (mode == MODE_INC) ? rx_byte + 8'd1 : rx_byte;

    always_ff @(posedge clk_i) begin
      if (wr_en) mem[wr_ptr] <= wr_byte;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + AW'(1);
        if (tx_hs[c]) rd_ptr <= rd_ptr + AW'(1);
        count <= count + LW'(wr_en) - LW'(tx_hs[c]);
      end
    end
  end

  logic [CW-1:0] act_cnt;

  // LED stays lit for ACT_CYCLES cycles after the most recent handshake.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      act_cnt <= '0;
      led_o   <= 1'b0;
    end else if (|rx_hs || |tx_hs) begin
      act_cnt <= CW'(ACT_CYCLES - 1);
      led_o   <= 1'b1;
    end else begin
      led_o <= (act_cnt != '0);
      if (act_cnt != '0) act_cnt <= act_cnt - CW'(1);
    end
  end

endmodule

// File: tb/tb_usb_cdc_loopback_mc.sv
// Directed self-checking bench for usb_cdc_loopback_mc (3 channels, depth 16, 8-cycle LED).
module tb_usb_cdc_loopback_mc;

  localparam int unsigned CH = 3;
  localparam int unsigned DP = 16;
  localparam int unsigned LW = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [8*CH-1:0]  rx_data = '0;
  logic [CH-1:0]    rx_valid = '0;
  logic [CH-1:0]    rx_ready;
  logic [8*CH-1:0]  tx_data;
  logic [CH-1:0]    tx_valid;
  logic [CH-1:0]    tx_ready = '0;
  logic [2*CH-1:0]  mode = '0;
  logic [CH*LW-1:0] level;
  logic             led;

  int n_chk  = 0;
  int n_pass = 0;

  usb_cdc_loopback_mc #(.CHANNELS(CH), .DEPTH(DP), .ACT_CYCLES(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready),
    .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
    .mode_i(mode), .level_o(level), .led_o(led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LW-1:0] lvl(input int c);
    return level[LW*c +: LW];
  endfunction

  function automatic logic [7:0] txd(input int c);
    return tx_data[8*c +: 8];
  endfunction

  initial begin
    int cnt;
    #1;
    chk("rst_level", 32'(level), 0);
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_led", 32'(led), 0);
    chk("rst_rx_ready", 32'(rx_ready), 32'h7);
    step();
    rst = 1'b0;
    step();

    // Echo with tx always ready: each byte visible one edge after its push.
    tx_ready = 3'b001;
    for (int i = 1; i <= 7; i++) begin
      rx_data[7:0] = 8'(i);
      rx_valid[0] = 1'b1;
      step();
      chk("echo_valid", 32'(tx_valid[0]), 1);
      chk("echo_data", 32'(txd(0)), i);
    end
    rx_valid[0] = 1'b0;
    step();
    chk("echo_level_drained", 32'(lvl(0)), 0);
    chk("echo_valid_drained", 32'(tx_valid[0]), 0);

    // Fill to full with tx stalled, then pop once while a 17th byte waits.
    tx_ready = '0;
    for (int i = 0; i < 16; i++) begin
      rx_data[7:0] = 8'h11 + 8'(i);
      rx_valid[0] = 1'b1;
      step();
    end
    chk("full_level", 32'(lvl(0)), 16);
    chk("full_rx_ready", 32'(rx_ready[0]), 0);
    rx_data[7:0] = 8'h21;
    step();
    chk("full_refused_level", 32'(lvl(0)), 16);
    tx_ready[0] = 1'b1;
    step();
    chk("full_pop_level", 32'(lvl(0)), 15);
    tx_ready[0] = 1'b0;
    step();
    chk("full_refill_level", 32'(lvl(0)), 16);
    rx_valid[0] = 1'b0;
    tx_ready[0] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("full_drain_data", 32'(txd(0)), 32'h12 + 32'(i));
      step();
    end
    chk("full_drain_level", 32'(lvl(0)), 0);

    // Increment mode, including the FF wrap.
    tx_ready[0] = 1'b0;
    mode[1:0] = 2'd1;
    rx_valid[0] = 1'b1;
    rx_data[7:0] = 8'h41;
    step();
    rx_data[7:0] = 8'hFF;
    step();
    rx_valid[0] = 1'b0;
    chk("inc_level", 32'(lvl(0)), 2);
    chk("inc_data0", 32'(txd(0)), 32'h42);
    tx_ready[0] = 1'b1;
    step();
    chk("inc_data1", 32'(txd(0)), 32'h00);
    step();
    chk("inc_level_drained", 32'(lvl(0)), 0);

    // Hold buffers without offering; release is immediate on mode change.
    mode[1:0] = 2'd3;
    for (int i = 0; i < 4; i++) begin
      rx_data[7:0] = 8'h21 + 8'(i);
      rx_valid[0] = 1'b1;
      step();
      chk("hold_valid", 32'(tx_valid[0]), 0);
    end
    rx_valid[0] = 1'b0;
    chk("hold_level", 32'(lvl(0)), 4);
    mode[1:0] = 2'd0;
    #1;
    chk("hold_release_valid", 32'(tx_valid[0]), 1);
    for (int i = 0; i < 4; i++) begin
      chk("hold_drain_data", 32'(txd(0)), 32'h21 + 32'(i));
      step();
    end
    chk("hold_drain_level", 32'(lvl(0)), 0);

    // Sink discards everything it accepts.
    mode[1:0] = 2'd2;
    for (int i = 0; i < 5; i++) begin
      rx_data[7:0] = 8'h60 + 8'(i);
      rx_valid[0] = 1'b1;
      #1;
      chk("sink_rx_ready", 32'(rx_ready[0]), 1);
      step();
    end
    rx_valid[0] = 1'b0;
    chk("sink_level", 32'(lvl(0)), 0);
    chk("sink_tx_valid", 32'(tx_valid[0]), 0);
    mode[1:0] = 2'd0;

    // Independent channels: ch0 drains, ch2 stalled.
    tx_ready = 3'b001;
    for (int i = 0; i < 5; i++) begin
      rx_data[7:0]   = 8'h80 + 8'(i);
      rx_data[23:16] = 8'hC0 + 8'(i);
      rx_valid = 3'b101;
      step();
      chk("mc_ch0_data", 32'(txd(0)), 32'h80 + 32'(i));
    end
    rx_valid = '0;
    step();
    chk("mc_ch0_level", 32'(lvl(0)), 0);
    chk("mc_ch1_level", 32'(lvl(1)), 0);
    chk("mc_ch1_valid", 32'(tx_valid[1]), 0);
    chk("mc_ch2_level", 32'(lvl(2)), 5);
    tx_ready = 3'b100;
    for (int i = 0; i < 5; i++) begin
      chk("mc_ch2_data", 32'(txd(2)), 32'hC0 + 32'(i));
      step();
    end
    chk("mc_ch2_level_drained", 32'(lvl(2)), 0);
    tx_ready = '0;

    // LED: let it go dark, then time one handshake.
    cnt = 0;
    while (led && cnt < 20) begin
      cnt++;
      step();
    end
    chk("led_dark", 32'(led), 0);
    rx_data[7:0] = 8'h55;
    rx_valid[0] = 1'b1;
    step();
    rx_valid[0] = 1'b0;
    cnt = 0;
    while (led && cnt < 50) begin
      cnt++;
      step();
    end
    chk("led_cycles", 32'(cnt), 8);

    // Async reset mid-stream with level 5.
    for (int i = 0; i < 4; i++) begin
      rx_data[7:0] = 8'h70 + 8'(i);
      rx_valid[0] = 1'b1;
      step();
    end
    rx_valid[0] = 1'b0;
    chk("prerst_level", 32'(lvl(0)), 5);
    chk("prerst_led", 32'(led), 1);
    rst = 1'b1;
    #1;
    chk("arst_level", 32'(lvl(0)), 0);
    chk("arst_tx_valid", 32'(tx_valid), 0);
    chk("arst_led", 32'(led), 0);
    chk("arst_rx_ready", 32'(rx_ready), 32'h7);
    step();
    rst = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
